nonce_result_scan: RTL and testbench



---
 rtl/nonce_scan_pkg.sv | 19 +
 rtl/nonce_min_tracker.sv | 49 ++++
 rtl/nonce_result_scan.sv | 156 +++++++++++++++
 tb/tb_nonce_result_scan.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nonce_scan_pkg.sv
// Shared types and constants for the nonce result scanner.
package nonce_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WR_HASH  = 3'd2,
        S_WR_NONCE = 3'd3,
        S_WR_COUNT = 3'd4,
        S_DONE     = 3'd5
    } scan_state_e;

    localparam logic [15:0] RES_HASH_OFS  = 16'd0;
    localparam logic [15:0] RES_NONCE_OFS = 16'd1;
    localparam logic [15:0] RES_COUNT_OFS = 16'd2;

    localparam logic [31:0] MAX_HASH = 32'hFFFF_FFFF;

endpackage

// File: rtl/nonce_min_tracker.sv
// Running minimum (lowest nonce wins ties) and below-target count over a
// stream of sampled hash words.
module nonce_min_tracker
    import nonce_scan_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_smp_vld,
    input  logic [31:0]      i_smp_word,
    input  logic [7:0]       i_smp_idx,
    input  logic [31:0]      i_target,
    output logic [31:0]      o_best_hash,
    output logic [7:0]       o_best_nonce,
    output logic [CNT_W-1:0] o_below_cnt
);

    logic [31:0]      r_best_hash;
    logic [7:0]       r_best_nonce;
    logic [CNT_W-1:0] r_below_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_best_hash  <= MAX_HASH;
            r_best_nonce <= 8'd0;
            r_below_cnt  <= '0;
        end else if (i_clr) begin
            r_best_hash  <= MAX_HASH;
            r_best_nonce <= 8'd0;
            r_below_cnt  <= '0;
        end else if (i_smp_vld) begin
            // strict compare keeps the earlier nonce on ties
            if (i_smp_word < r_best_hash) begin
                r_best_hash  <= i_smp_word;
                r_best_nonce <= i_smp_idx;
            end
            if (i_smp_word < i_target) begin
                r_below_cnt <= r_below_cnt + 1'b1;
            end
        end
    end

    assign o_best_hash  = r_best_hash;
    assign o_best_nonce = r_best_nonce;
    assign o_below_cnt  = r_below_cnt;

endmodule

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES hash words from memory, then writes {min hash, its nonce,
// below-target count} as a 3-word record.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_READ     | streaming addresses, sampling words two edges later
// S_WR_HASH  | issue write of minimum hash
// S_WR_NONCE | issue write of best nonce
// S_WR_COUNT | issue write of below-target count
// S_DONE     | retire last write, raise done, then wait for next start
module nonce_result_scan
    import nonce_scan_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int CNT_W      = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int RD_W = $clog2(NUM_NONCES + 1);

    scan_state_e      r_state;
    logic             r_done;
    logic             r_found;
    logic             r_mem_we;
    logic [15:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [15:0]      r_hash_base;
    logic [15:0]      r_res_base;
    logic [31:0]      r_target;
    logic [RD_W-1:0]  r_rd_cnt;
    logic [7:0]       r_smp_cnt;
    logic [1:0]       r_pipe;

    logic             w_accept;
    logic             w_smp_vld;
    logic [31:0]      w_best_hash;
    logic [7:0]       w_best_nonce;
    logic [CNT_W-1:0] w_below_cnt;

    // In DONE with mem_we still high the count write is retiring; start waits.
    assign w_accept  = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && !r_mem_we));
    assign w_smp_vld = (r_state == S_READ) && r_pipe[1];

    nonce_min_tracker #(
        .CNT_W(CNT_W)
    ) u_tracker (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (w_accept),
        .i_smp_vld    (w_smp_vld),
        .i_smp_word   (mem_read_data),
        .i_smp_idx    (r_smp_cnt),
        .i_target     (r_target),
        .o_best_hash  (w_best_hash),
        .o_best_nonce (w_best_nonce),
        .o_below_cnt  (w_below_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 32'd0;
            r_hash_base <= 16'd0;
            r_res_base  <= 16'd0;
            r_target    <= 32'd0;
            r_rd_cnt    <= '0;
            r_smp_cnt   <= 8'd0;
            r_pipe      <= 2'b00;
        end else if (w_accept) begin
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= hash_addr;
            r_hash_base <= hash_addr;
            r_res_base  <= result_addr;
            r_target    <= target;
            r_rd_cnt    <= RD_W'(1);
            r_smp_cnt   <= 8'd0;
            r_pipe      <= 2'b01;
            r_state     <= S_READ;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_READ: begin
                    // r_pipe tracks the two-edge read latency of each issued address
                    if (r_rd_cnt < RD_W'(NUM_NONCES)) begin
                        r_mem_addr <= r_hash_base + 16'(r_rd_cnt);
                        r_rd_cnt   <= r_rd_cnt + 1'b1;
                        r_pipe     <= {r_pipe[0], 1'b1};
                    end else begin
                        r_pipe     <= {r_pipe[0], 1'b0};
                    end
                    if (r_pipe[1]) begin
                        r_smp_cnt <= r_smp_cnt + 8'd1;
                        if (r_smp_cnt == 8'(NUM_NONCES - 1)) begin
                            r_state <= S_WR_HASH;
                        end
                    end
                end
                S_WR_HASH: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_res_base + RES_HASH_OFS;
                    r_mem_wdata <= w_best_hash;
                    r_state     <= S_WR_NONCE;
                end
                S_WR_NONCE: begin
                    r_mem_addr  <= r_res_base + RES_NONCE_OFS;
                    r_mem_wdata <= {24'd0, w_best_nonce};
                    r_state     <= S_WR_COUNT;
                end
                S_WR_COUNT: begin
                    r_mem_addr  <= r_res_base + RES_COUNT_OFS;
                    r_mem_wdata <= 32'(w_below_cnt);
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (r_mem_we) begin
                        r_mem_we <= 1'b0;
                        r_done   <= 1'b1;
                        r_found  <= (w_below_cnt != '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done           = r_done;
    assign found          = r_found;
    assign best_nonce     = w_best_nonce;
    assign best_hash      = w_best_hash;
    assign mem_clk        = clk;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Directed + randomized bench for nonce_result_scan with a behavioural
// memory and a reference model of min/nonce/count.
module tb_nonce_result_scan;

    localparam int N = 16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks   = 0;
    int failures = 0;

    nonce_result_scan #(
        .NUM_NONCES(N),
        .CNT_W(9)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read image written by the bench; DUT writes land in a separate log array.
    logic [31:0] bk_mem [0:65535];
    logic [31:0] wr_mem [0:65535];
    int          wr_count = 0;

    always @(posedge clk) begin
        mem_read_data <= bk_mem[mem_addr];
        if (mem_we) begin
            wr_mem[mem_addr] <= mem_write_data;
            wr_count         <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] ha, input logic [31:0] tg,
                         output logic [31:0] bh, output logic [7:0] bn, output int cnt);
        logic [31:0] w;
        bh  = 32'hFFFF_FFFF;
        bn  = 8'd0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            w = bk_mem[16'(ha + 16'(i))];
            if (w < bh) begin
                bh = w;
                bn = 8'(i);
            end
            if (w < tg) cnt++;
        end
    endtask

    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg,
                            input int pulse_k, input int rst_k, input bit scramble);
        logic [31:0] eb;
        logic [7:0]  en;
        int          ec;
        int          wc0;
        int          wbase;
        bit          exp_we;
        model(ha, tg, eb, en, ec);
        @(negedge clk);
        hash_addr   = ha;
        result_addr = ra;
        target      = tg;
        start       = 1'b1;
        wc0         = wr_count;
        for (int k = 0; k <= N + 5; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 0 && scramble) begin
                target      = $urandom;
                result_addr = ~ra;
            end
            exp_we = (k >= N + 2) && (k <= N + 4);
            chk($sformatf("we_k%0d", k), 32'(mem_we), 32'(exp_we));
            chk($sformatf("done_k%0d", k), 32'(done), 32'(k >= N + 5));
            if (k < N)
                chk($sformatf("rd_addr_k%0d", k), 32'(mem_addr), 32'(16'(ha + 16'(k))));
            if (k == N + 2) begin
                chk("wr_addr_hash", 32'(mem_addr), 32'(16'(ra)));
                chk("wr_data_hash", mem_write_data, eb);
            end
            if (k == N + 3) begin
                chk("wr_addr_nonce", 32'(mem_addr), 32'(16'(ra + 16'd1)));
                chk("wr_data_nonce", mem_write_data, 32'(en));
            end
            if (k == N + 4) begin
                chk("wr_addr_count", 32'(mem_addr), 32'(16'(ra + 16'd2)));
                chk("wr_data_count", mem_write_data, 32'(ec));
            end
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
                chk("rst_we", 32'(mem_we), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_addr", 32'(mem_addr), 32'd0);
                chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
                chk("rst_writes_before", 32'(wr_count - wc0),
                    32'((rst_k >= N + 3) ? rst_k - (N + 2) : 0));
                wbase = wr_count;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_no_writes", 32'(wr_count - wbase), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (k + 1 == pulse_k) begin
                @(negedge clk);
                start = 1'b1;
            end
        end
        chk("found", 32'(found), 32'(ec != 0));
        chk("best_nonce", 32'(best_nonce), 32'(en));
        chk("best_hash", best_hash, eb);
        chk("rec_hash", wr_mem[ra], eb);
        chk("rec_nonce", wr_mem[16'(ra + 16'd1)], 32'(en));
        chk("rec_count", wr_mem[16'(ra + 16'd2)], 32'(ec));
        chk("rec_writes", 32'(wr_count - wc0), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", 32'(done), 32'd1);
        chk("hash_hold", best_hash, eb);
    endtask

    logic [15:0] ha_r;
    logic [31:0] tg_r;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        hash_addr   = 16'd0;
        result_addr = 16'd0;
        target      = 32'd0;
        #12;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_found", 32'(found), 32'd0);
        chk("reset_nonce", 32'(best_nonce), 32'd0);
        chk("reset_hash", best_hash, 32'hFFFF_FFFF);
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // descending words: minimum is the last nonce, nothing below target
        for (int i = 0; i < N; i++) bk_mem[16'h0010 + 16'(i)] = 32'hF000_0000 - 32'(i);
        run_scan(16'h0010, 16'h0020, 32'h0000_0001, -1, -1, 1'b0);

        // equal minima at 5 and 9, start pulsed mid-scan, inputs disturbed after accept
        for (int i = 0; i < N; i++) bk_mem[16'h0010 + 16'(i)] = 32'h8000_0000;
        bk_mem[16'h0015] = 32'h0000_1234;
        bk_mem[16'h0019] = 32'h0000_1234;
        run_scan(16'h0010, 16'h0020, 32'h0001_0000, 8, -1, 1'b1);

        // all-ones words: strict compares leave count at zero, nonce at zero
        for (int i = 0; i < N; i++) bk_mem[16'h0010 + 16'(i)] = 32'hFFFF_FFFF;
        run_scan(16'h0010, 16'h0020, 32'hFFFF_FFFF, -1, -1, 1'b0);

        // reset mid-read, then reset mid-write, each followed by a clean scan
        for (int i = 0; i < N; i++) bk_mem[16'h0010 + 16'(i)] = $urandom;
        run_scan(16'h0010, 16'h0020, 32'h8000_0000, -1, 10, 1'b0);
        run_scan(16'h0010, 16'h0020, 32'h8000_0000, -1, -1, 1'b0);
        run_scan(16'h0010, 16'h0020, 32'h4000_0000, -1, N + 3, 1'b0);
        run_scan(16'h0010, 16'h0020, 32'h4000_0000, -1, -1, 1'b0);

        // randomized scans, first one wrapping across address 0
        for (int t = 0; t < 5; t++) begin
            ha_r = (t == 0) ? 16'hFFF8 : 16'($urandom);
            tg_r = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2000)) : $urandom;
            for (int i = 0; i < N; i++) begin
                bk_mem[16'(ha_r + 16'(i))] = ($urandom_range(0, 1) == 1) ?
                    32'($urandom_range(0, 1000)) : $urandom;
            end
            run_scan(ha_r, 16'(ha_r + 16'h8000), tg_r, -1, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
